lieat_exu_vpu_vseq: RTL
=======================

// Module: lieat_exu_vpu_vseq
// PURPOSE
//  Element sequencer directly upstream of the 8-bit vector units (vunit08).
//  - Accepts one vector add/sub/rsub op per handshake: two VLEN-bit sources, an op select and a vector length.
//  - Slices the operands into 8-bit elements and issues LANES elements per beat to LANES parallel vunit08 instances.
//  - Gathers the per-element results into a VLEN-bit result and presents it downstream with valid/ready.
// PARAMETERS
//  VLEN   64  vector register width in bits; must be a multiple of 8*LANES
//  LANES  2   number of vunit08 instances driven in parallel (1,2,4,8 legal)
// PORTS
//  clock          in   1           single clock; all state updates on the rising edge
//  reset          in   1           synchronous, active-high reset
//  vseq_i_valid   in   1           new op offered
//  vseq_i_ready   out  1           sequencer can accept a new op
//  vseq_i_vs1     in   VLEN        source 1 (element k = bits[8k+7:8k]); becomes vunit op1
//  vseq_i_vs2     in   VLEN        source 2; becomes vunit op2
//  vseq_i_vadd    in   1           op select: op1+op2
//  vseq_i_vsub    in   1           op select: op1-op2
//  vseq_i_vrsub   in   1           op select: op2-op1
//  vseq_i_vl      in   4           active element count, 0..VLEN/8
//  vseq_u_valid   out  1           beat valid to all lanes
//  vseq_u_op1     out  LANES*8     lane L op1 = bits[8L+7:8L]
//  vseq_u_op2     out  LANES*8     lane L op2
//  vseq_u_vadd    out  1           latched op select, fanned out to every lane
//  vseq_u_vsub    out  1           latched op select
//  vseq_u_vrsub   out  1           latched op select
//  vseq_u_o_valid in   1           AND of lane o_valid; lane results present this cycle
//  vseq_u_o_data  in   LANES*8     lane results, same packing as op1
//  vseq_o_valid   out  1           full result available
//  vseq_o_ready   in   1           downstream accepts result
//  vseq_o_data    out  VLEN        gathered result vector
// BEHAVIOUR
//  - Reset: FSM=IDLE; beat=0; operand/op/vl registers and result register cleared.
//    Output values in reset: i_ready=1, u_valid=0, u_op*=0, u_vadd/vsub/vrsub=0, o_valid=0, o_data=0.
//  - Reset mid-op aborts: the partial result is discarded and no o_valid is produced.
//  - FSM IDLE: i_ready=1. On i_valid&i_ready:
//    - latch vs1, vs2, op selects and vl_eff=min(vl, VLEN/8);
//    - clear the result register; beat=0;
//    - next state RUN, or DONE when vl_eff==0.
//  - FSM RUN: i_ready=0, u_valid=1.
//    - u_op1/u_op2 = elements [beat*LANES +: LANES] of latched vs1/vs2; u_vadd/vsub/vrsub = latched selects.
//    - If u_o_valid=1: lane L result is written to element beat*LANES+L when that index < vl_eff;
//      otherwise that element is written 0.
//    - Then if beat==last: go to DONE; else beat++.
//      last = ceil(vl_eff/LANES)-1. Early exit: beats past vl_eff are not issued.
//    - If u_o_valid=0: stall; beat and result are held and u_valid stays 1.
//  - FSM DONE: o_valid=1, o_data=result register. On o_ready go to IDLE. Result is held stable while o_ready=0.
//  - No accept in RUN or DONE. Back-to-back ops have one IDLE bubble.
//  - Latency from accept to o_valid: 1+ceil(vl_eff/LANES) cycles with no stalls. vl_eff==0 gives o_valid after 1 cycle.
//  - Tail elements (index >= vl_eff) are zero-filled (tail-agnostic, zero policy).
//  - Arithmetic is performed only in vunit08, modulo 2^8 per element, with no carry between elements.
//  - Select encodings:
//    - All selects 0: the lanes return 0, so active elements are 0.
//    - More than one select: the lanes return the OR of the selected results; passed through unchanged, no error flagged.
//  - Beat counter width = max(1, clog2(VLEN/(8*LANES))). It never wraps past last.
// TESTING
//  - vl=8, vadd, vs1=0x0807060504030201, vs2=0x0101010101010101 -> 4 beats; o_valid 5 cycles after accept;
//    o_data=0x0908070605040302.
//  - vl=8, vsub, vs1=0x00..00, vs2=0x0101010101010101 -> o_data=0xFFFFFFFFFFFFFFFF (per-element wrap, no borrow chain).
//  - vl=3, vrsub, vs1=0x01.., vs2=0x05.. -> 2 beats only;
//    o_data=0x0000000000040404 (element 3 zero even though issued in beat 1).
//  - vl=0, any op -> no u_valid pulse; o_valid on the cycle after accept; o_data=0.
//  - vl=8, stall: u_o_valid=0 for 3 cycles in beat 1 -> beat 1 operands held, result unchanged;
//    o_valid arrives 3 cycles later; o_ready=0 for 2 cycles keeps o_data stable and i_ready=0.
//  - reset asserted during beat 2 -> next cycle IDLE, i_ready=1, o_valid=0, o_data=0;
//    a following op produces a correct, uncorrupted result.

Source files
------------

// File: rtl/lieat_exu_vpu_vseq.sv
`default_nettype none
// ============================================================================
// Module   : lieat_exu_vpu_vseq
// Brief    : Element sequencer feeding LANES parallel 8-bit vector units.
//            Slices VLEN-bit operands into beats and gathers lane results.
// Revision : 1.0 - initial release
// ============================================================================
module lieat_exu_vpu_vseq #(
    parameter int VLEN  = 64,
    parameter int LANES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 vseq_i_valid,
    output logic                 vseq_i_ready,
    input  logic [VLEN-1:0]      vseq_i_vs1,
    input  logic [VLEN-1:0]      vseq_i_vs2,
    input  logic                 vseq_i_vadd,
    input  logic                 vseq_i_vsub,
    input  logic                 vseq_i_vrsub,
    input  logic [3:0]           vseq_i_vl,
    output logic                 vseq_u_valid,
    output logic [LANES*8-1:0]   vseq_u_op1,
    output logic [LANES*8-1:0]   vseq_u_op2,
    output logic                 vseq_u_vadd,
    output logic                 vseq_u_vsub,
    output logic                 vseq_u_vrsub,
    input  logic                 vseq_u_o_valid,
    input  logic [LANES*8-1:0]   vseq_u_o_data,
    output logic                 vseq_o_valid,
    input  logic                 vseq_o_ready,
    output logic [VLEN-1:0]      vseq_o_data
);

    localparam int NELEM  = VLEN / 8;
    localparam int NBEATS = NELEM / LANES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int VLW    = ($clog2(NELEM + 1) > 4) ? $clog2(NELEM + 1) : 4;
    localparam int LW     = LANES * 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state;
    logic [BW-1:0]   beat;
    logic [BW-1:0]   last_beat;
    logic [VLEN-1:0] vs1_q;
    logic [VLEN-1:0] vs2_q;
    logic            vadd_q;
    logic            vsub_q;
    logic            vrsub_q;
    logic [VLW-1:0]  vl_eff;
    logic [VLEN-1:0] result;

    logic            accept;
    logic            running;
    logic [VLW-1:0]  vl_clamp;
    int              nbeats_new;
    logic [BW-1:0]   last_new;

    assign accept  = vseq_i_valid && (state == ST_IDLE);
    assign running = (state == ST_RUN);

    // Clamp vl to the register width and precompute the final beat index so
    // the run loop only needs an equality compare.
    always_comb begin
        vl_clamp   = VLW'(vseq_i_vl);
        if (int'(vseq_i_vl) > NELEM) begin
            vl_clamp = VLW'(NELEM);
        end
        nbeats_new = (int'(vl_clamp) + LANES - 1) / LANES;
        last_new   = '0;
        if (nbeats_new > 0) begin
            last_new = BW'(nbeats_new - 1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            beat      <= '0;
            last_beat <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vadd_q    <= 1'b0;
            vsub_q    <= 1'b0;
            vrsub_q   <= 1'b0;
            vl_eff    <= '0;
            result    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        vs1_q     <= vseq_i_vs1;
                        vs2_q     <= vseq_i_vs2;
                        vadd_q    <= vseq_i_vadd;
                        vsub_q    <= vseq_i_vsub;
                        vrsub_q   <= vseq_i_vrsub;
                        vl_eff    <= vl_clamp;
                        last_beat <= last_new;
                        beat      <= '0;
                        result    <= '0;
                        state     <= (vl_clamp == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (vseq_u_o_valid) begin
                        // Elements beyond vl_eff in the final beat are zero-filled.
                        for (int l = 0; l < LANES; l++) begin
                            if ((int'(beat) * LANES + l) < int'(vl_eff)) begin
                                result[(int'(beat) * LANES + l) * 8 +: 8] <= vseq_u_o_data[l*8 +: 8];
                            end else begin
                                result[(int'(beat) * LANES + l) * 8 +: 8] <= 8'd0;
                            end
                        end
                        if (beat == last_beat) begin
                            state <= ST_DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (vseq_o_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign vseq_i_ready = (state == ST_IDLE);
    assign vseq_u_valid = running;
    assign vseq_u_op1   = running ? vs1_q[int'(beat) * LW +: LW] : '0;
    assign vseq_u_op2   = running ? vs2_q[int'(beat) * LW +: LW] : '0;
    assign vseq_u_vadd  = running & vadd_q;
    assign vseq_u_vsub  = running & vsub_q;
    assign vseq_u_vrsub = running & vrsub_q;
    assign vseq_o_valid = (state == ST_DONE);
    assign vseq_o_data  = result;

endmodule
`default_nettype wire
